// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry FIFO between fetch and decode, valid/ready on both sides, synchronous flush.
// Optional build macro IF_ID_QUEUE_NOP_FILL_EN: present NOP_INSTR and zero PCs while the queue is empty.
module if_id_queue #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 2,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h00000013)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         f_valid,
   output logic                         f_ready,
   input  logic [DATA_WIDTH-1:0]        RD,
   input  logic [DATA_WIDTH-1:0]        PCF,
   input  logic [DATA_WIDTH-1:0]        PC_PlusF,
   input  logic                         flush,
   input  logic                         d_ready,
   output logic                         d_valid,
   output logic [DATA_WIDTH-1:0]        InstrD,
   output logic [DATA_WIDTH-1:0]        PCD,
   output logic [DATA_WIDTH-1:0]        PC_PlusD,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int             PW       = $clog2(DEPTH);
   localparam int             CW       = $clog2(DEPTH+1);
   localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

   logic [DATA_WIDTH-1:0] instr_q [DEPTH];
   logic [DATA_WIDTH-1:0] instr_d [DEPTH];
   logic [DATA_WIDTH-1:0] pc_q    [DEPTH];
   logic [DATA_WIDTH-1:0] pc_d    [DEPTH];
   logic [DATA_WIDTH-1:0] pcp_q   [DEPTH];
   logic [DATA_WIDTH-1:0] pcp_d   [DEPTH];
   logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  push_s, pop_s, d_valid_s, f_ready_s;

   // Handshake qualifiers depend only on registered occupancy, so f_ready has no path from d_ready.
   always_comb begin
      d_valid_s = (count_q != {CW{1'b0}});
      f_ready_s = (count_q != FULL_CNT);
      push_s    = f_valid && f_ready_s;
      pop_s     = d_valid_s && d_ready;
   end

   // Next state: flush discards everything, otherwise push writes at wp and pop advances rp.
   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      pcp_d   = pcp_q;
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      if (flush) begin
         wp_d    = {PW{1'b0}};
         rp_d    = {PW{1'b0}};
         count_d = {CW{1'b0}};
      end else begin
         if (push_s) begin
            instr_d[wp_q] = RD;
            pc_d[wp_q]    = PCF;
            pcp_d[wp_q]   = PC_PlusF;
            wp_d          = wp_q + PW'(1'b1);
         end else begin
            wp_d = wp_q;
         end
         if (pop_s) begin
            rp_d = rp_q + PW'(1'b1);
         end else begin
            rp_d = rp_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers; reset clears pointers, occupancy and all storage at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q    <= {PW{1'b0}};
         rp_q    <= {PW{1'b0}};
         count_q <= {CW{1'b0}};
         instr_q <= '{default: {DATA_WIDTH{1'b0}}};
         pc_q    <= '{default: {DATA_WIDTH{1'b0}}};
         pcp_q   <= '{default: {DATA_WIDTH{1'b0}}};
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         pcp_q   <= pcp_d;
      end
   end

   // Head entry is read from registered storage at rp.
   always_comb begin
`ifdef IF_ID_QUEUE_NOP_FILL_EN
      if (d_valid_s) begin
         InstrD   = instr_q[rp_q];
         PCD      = pc_q[rp_q];
         PC_PlusD = pcp_q[rp_q];
      end else begin
         InstrD   = NOP_INSTR;
         PCD      = {DATA_WIDTH{1'b0}};
         PC_PlusD = {DATA_WIDTH{1'b0}};
      end
`else
      InstrD   = instr_q[rp_q];
      PCD      = pc_q[rp_q];
      PC_PlusD = pcp_q[rp_q];
`endif
   end

   assign d_valid = d_valid_s;
   assign f_ready = f_ready_s;
   assign count   = count_q;

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- Holds up to DEPTH fetched instructions, each with its PC and PC+4, in a small FIFO between the fetch and decode stages.
- Fetch and decode are decoupled by valid/ready handshakes, so the queue absorbs decode stalls.
- Supports a synchronous flush for branch/jump redirects.

Parameters:
- DATA_WIDTH, 32, width of the instruction, PC and PC+4 fields.
- DEPTH, 2, number of entries; power of two, minimum 2.
- NOP_INSTR, 32'h00000013, instruction presented on InstrD when the queue is empty (only used with the optional feature).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- f_valid  input  1  fetch presents a valid entry this cycle.
- f_ready  output  1  queue can accept an entry; equals !full, with no path from d_ready.
- RD  input  DATA_WIDTH  fetched instruction.
- PCF  input  DATA_WIDTH  fetch PC.
- PC_PlusF  input  DATA_WIDTH  fetch PC+4.
- flush  input  1  discard all queued entries; synchronous.
- d_ready  input  1  decode consumes the head entry this cycle (i.e. not stalled).
- d_valid  output  1  head entry is valid.
- InstrD  output  DATA_WIDTH  head instruction.
- PCD  output  DATA_WIDTH  head PC.
- PC_PlusD  output  DATA_WIDTH  head PC+4.
- count  output  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Definitions: push = f_valid && f_ready; pop = d_valid && d_ready.
- Storage: three DATA_WIDTH arrays of DEPTH entries; write pointer wp, read pointer rp, occupancy count.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Reset: while rst is high, asynchronously clear wp, rp and count.
  - Result: d_valid=0, f_ready=1, count=0.
  - Without the optional feature, InstrD/PCD/PC_PlusD read 0; all storage entries are cleared to 0.
  - Reset asserted mid-operation discards all entries immediately, with no partial update.
- Outputs are driven from the registered head entry (entry at rp). There is no combinational path from any F-side input to any D-side output.
- Latency: an entry pushed on edge N is visible on the D-side outputs after edge N, i.e. one cycle, the same as the old pipeline register.
- d_valid = (count != 0).
- f_ready = (count != DEPTH).
- Per-edge priority:
  1. flush: wp <= 0, rp <= 0, count <= 0. Any same-cycle push and pop are discarded. Next cycle d_valid=0 and f_ready=1.
  2. push only: write entry at wp, wp+1, count+1.
  3. pop only: rp+1, count-1.
  4. push and pop together (only possible when 0 < count < DEPTH): write and advance both pointers; count unchanged.
- Full (count == DEPTH): f_ready=0; f_valid is ignored; existing entries hold.
- Empty (count == 0): d_ready is ignored; a pop cannot occur.
- Decode stalled (d_ready=0): head entry and all D-side outputs hold stable.

Optional Feature:
- Macro: IF_ID_QUEUE_NOP_FILL_EN.
- Defined: when d_valid=0, InstrD = NOP_INSTR and PCD = PC_PlusD = 0. This lets decode run bubble-safe without gating on d_valid.
- Undefined: when empty, InstrD/PCD/PC_PlusD show the stale entry at rp. The value is don't-care; consumers must qualify with d_valid.

Test Plan:
- Reset, then idle: rst pulse with no clk edge -> d_valid=0, f_ready=1, count=0 asynchronously; InstrD=0x00000013 with the feature, 0 without.
- Single pass: push RD=0x00500093, PCF=0x0, PC_PlusF=0x4 with d_ready=1 -> next cycle d_valid=1, InstrD=0x00500093, PCD=0x0, PC_PlusD=0x4; following cycle d_valid=0.
- Stall to full: d_ready=0, push PCF=0x0, then 0x4, then 0x8 -> count=2 and f_ready=0 after the second push; third push is ignored; after d_ready=1, pops deliver PCD=0x0 then 0x4.
- Simultaneous push/pop at count=1: head PCD=0x10, push PCF=0x14 with d_ready=1 -> count stays 1; next PCD=0x14.
- Flush with push: count=2, flush=1 together with f_valid=1 (PCF=0x20) -> next cycle count=0, d_valid=0; entry 0x20 is not present afterwards.
- Wrap-around: stream 8 sequential PCs 0x0..0x1C through DEPTH=2 with alternating d_ready -> PCD order is exact, no loss or duplication; assert reset mid-stream -> count=0 immediately.
